stack_unit: RTL and testbench

- Hardware operand stack answering the push/pop/top command strobes issued by the multicycle controller. It is the responder end of the stack interface.
- Holds DEPTH words of WIDTH bits and returns the popped or peeked word on a registered output one cycle after the command.
- Reports occupancy and full/empty status, and keeps sticky overflow/underflow error flags that the controller or a debug path reads and clears.

---
 rtl/stack_pkg.sv | 33 +++
 rtl/stack_regfile.sv | 28 ++
 rtl/stack_unit.sv | 141 ++++++++++++++
 tb/tb_stack_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: default geometry and the resolved
// command set that stack_unit decodes from its push/pop/top strobes.
package stack_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W_DEF = $clog2(DEPTH_DEF) + 1;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_PUSH      = 3'd1,
        CMD_POP       = 3'd2,
        CMD_PEEK      = 3'd3,
        CMD_REPLACE   = 3'd4,
        CMD_PEEK_PUSH = 3'd5
    } cmd_e;

    // pop dominates top; push combined with pop is a replace of the top entry
    function automatic cmd_e resolve_cmd(input logic push, input logic pop, input logic top);
        cmd_e c;
        case ({push, pop, top})
            3'b000:          c = CMD_NOP;
            3'b001:          c = CMD_PEEK;
            3'b010, 3'b011:  c = CMD_POP;
            3'b100:          c = CMD_PUSH;
            3'b101:          c = CMD_PEEK_PUSH;
            3'b110, 3'b111:  c = CMD_REPLACE;
            default:         c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port and one combinational read port.
module stack_regfile
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents deliberately have no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack responder: resolves push/pop/top strobes, tracks occupancy,
// returns read data one cycle later and keeps sticky overflow/underflow flags.
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             top,
    input  logic [WIDTH-1:0] d_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] d_out,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    cmd_e             cmd_s;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             we_s;
    logic [AW-1:0]    waddr_s;
    logic [AW-1:0]    top_idx_s;
    logic [WIDTH-1:0] rdata_s;
    logic             is_full_s, is_empty_s;

    assign cmd_s      = resolve_cmd(push, pop, top);
    assign is_full_s  = (count_q == FULL_CNT);
    assign is_empty_s = (count_q == {CNT_W{1'b0}});
    assign top_idx_s  = count_q[AW-1:0] - AW'(1);

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (we_s & ~rst),
        .waddr (waddr_s),
        .wdata (d_in),
        .raddr (top_idx_s),
        .rdata (rdata_s)
    );

    // Next-state for count, read data, valid pulse, sticky flags and write port
    always_comb begin
        count_d = count_q;
        d_out_d = d_out_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q & ~clr_err;
        unf_d   = unf_q & ~clr_err;
        we_s    = 1'b0;
        waddr_s = count_q[AW-1:0];

        // Read half of the command: pop, peek, replace and peek+push all return old top
        if (cmd_s == CMD_POP || cmd_s == CMD_PEEK || cmd_s == CMD_REPLACE || cmd_s == CMD_PEEK_PUSH) begin
            if (is_empty_s) begin
                unf_d = 1'b1;
            end else begin
                d_out_d = rdata_s;
                valid_d = 1'b1;
            end
        end else begin
            valid_d = 1'b0;
        end

        case (cmd_s)
            CMD_NOP, CMD_PEEK: begin
                count_d = count_q;
            end
            CMD_PUSH, CMD_PEEK_PUSH: begin
                if (is_full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    we_s    = 1'b1;
                    count_d = count_q + ONE_CNT;
                end
            end
            CMD_POP: begin
                if (is_empty_s) begin
                    count_d = count_q;
                end else begin
                    count_d = count_q - ONE_CNT;
                end
            end
            CMD_REPLACE: begin
                we_s = 1'b1;
                if (is_empty_s) begin
                    waddr_s = {AW{1'b0}};
                    count_d = ONE_CNT;
                end else begin
                    waddr_s = top_idx_s;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
            d_out_q <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            d_out_q <= d_out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign d_out     = d_out_q;
    assign valid     = valid_q;
    assign count     = count_q;
    assign full      = is_full_s;
    assign empty     = is_empty_s;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_stack_unit;
    import stack_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             push, pop, top, clr_err;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             valid, full, empty, overflow, underflow;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .top       (top),
        .d_in      (d_in),
        .clr_err   (clr_err),
        .d_out     (d_out),
        .valid     (valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: stack as a queue, outputs derived from the command rules
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid, m_ovf, m_unf;

    always @(posedge clk) begin
        cmd_e c;
        bit   was_empty;
        if (rst) begin
            mq.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            if (push && pop)      c = CMD_REPLACE;
            else if (pop)         c = CMD_POP;
            else if (push && top) c = CMD_PEEK_PUSH;
            else if (push)        c = CMD_PUSH;
            else if (top)         c = CMD_PEEK;
            else                  c = CMD_NOP;
            was_empty = (mq.size() == 0);
            m_valid = 1'b0;
            if (clr_err) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (c != CMD_NOP && c != CMD_PUSH) begin
                if (was_empty) m_unf = 1'b1;
                else begin
                    m_dout  = mq[mq.size()-1];
                    m_valid = 1'b1;
                end
            end
            case (c)
                CMD_REPLACE: begin
                    if (was_empty) mq.push_back(d_in);
                    else mq[mq.size()-1] = d_in;
                end
                CMD_POP: begin
                    if (!was_empty) void'(mq.pop_back());
                end
                CMD_PUSH, CMD_PEEK_PUSH: begin
                    if (mq.size() < DEPTH) mq.push_back(d_in);
                    else m_ovf = 1'b1;
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Compare DUT against model on every falling edge once reset has been seen
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count", 32'(count), 32'(mq.size()));
            check("m_full", 32'(full), 32'(mq.size() == DEPTH));
            check("m_empty", 32'(empty), 32'(mq.size() == 0));
            check("m_valid", 32'(valid), 32'(m_valid));
            check("m_d_out", 32'(d_out), 32'(m_dout));
            check("m_overflow", 32'(overflow), 32'(m_ovf));
            check("m_underflow", 32'(underflow), 32'(m_unf));
        end
    end

    task automatic cyc(input logic r, input logic pu, input logic po, input logic tp,
                       input logic [WIDTH-1:0] d, input logic ce);
        rst = r; push = pu; pop = po; top = tp; d_in = d; clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_en = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        idle();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_d_out", 32'(d_out), 32'h0);
        check("rst_flags", 32'({overflow, underflow}), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h11 + i), 1'b0);
        check("fill_count", 32'(count), 32'd8);
        check("fill_full", 32'(full), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);

        // Drain
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            check("drain_d_out", 32'(d_out), 32'(8'h18 - i));
            check("drain_valid", 32'(valid), 32'd1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("unf_valid", 32'(valid), 32'd0);
        check("unf_flag", 32'(underflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_flags", 32'({overflow, underflow}), 32'd0);

        // Replace at full
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h11 + i), 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 1'b0);
        check("rep_d_out", 32'(d_out), 32'h18);
        check("rep_valid", 32'(valid), 32'd1);
        check("rep_count", 32'(count), 32'd8);
        check("rep_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("rep_peek", 32'(d_out), 32'hAA);

        // Peek and push+peek
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("peek_d_out", 32'(d_out), 32'h05);
        check("peek_count", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h06, 1'b0);
        check("pkpush_d_out", 32'(d_out), 32'h05);
        check("pkpush_count", 32'(count), 32'd2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("pkpush_pop", 32'(d_out), 32'h06);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h30 + i), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("rstmid_count", 32'(count), 32'd0);
        check("rstmid_valid", 32'(valid), 32'd0);
        check("rstmid_d_out", 32'(d_out), 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("rstmid_unf", 32'(underflow), 32'd1);

        // Randomized traffic, alternating push-heavy and pop-heavy phases
        for (int n = 0; n < 3000; n++) begin
            int pbias;
            pbias = ((n / 100) % 2 == 0) ? 70 : 30;
            cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < pbias) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < (100 - pbias)) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                8'($urandom),
                ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end
        idle();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
